// File: rtl/pacman_mover.sv
// Per-frame Pac-Man sprite motion: keycode turn buffer, clamped stepping inside the playfield, mouth animation.
// Every register updates once per frame_clk edge when enable is set; all of it holds when enable is low.
module pacman_mover #(
  parameter int X_CENTER    = 202,
  parameter int Y_CENTER    = 253,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 404,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 447,
  parameter int SIZE        = 13,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 8,
  parameter int ANIM_DIV    = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic [1:0] dir,
  output logic       moving,
  output logic       turn_pending,
  output logic [1:0] anim_frame
);

  localparam logic [10:0] X_LO   = 11'(X_MIN + SIZE);
  localparam logic [10:0] X_HI   = 11'(X_MAX - SIZE);
  localparam logic [10:0] Y_LO   = 11'(Y_MIN + SIZE);
  localparam logic [10:0] Y_HI   = 11'(Y_MAX - SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [7:0]  HOLD8  = 8'(HOLD_FRAMES);
  localparam logic [7:0]  ANIM_LAST = 8'(ANIM_DIV - 1);

  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_UP    = 2'd3;

  typedef enum logic [1:0] {IDLE, MOVING, STOPPED} state_t;

  state_t     state, state_nxt;
  logic [1:0] pend_dir, pend_dir_nxt;
  logic [7:0] pend_cnt, pend_cnt_nxt;
  logic       turn_pending_nxt;
  logic [7:0] anim_cnt, anim_cnt_nxt;
  logic [1:0] anim_frame_nxt, dir_nxt;
  logic [10:0] x11, y11, x_nxt, y_nxt;
  logic       key_vld, live, turn_ok, cont_ok, move_vld;
  logic [1:0] key_dir, req_dir, move_dir;

  assign BallS  = 10'(SIZE);
  assign moving = (state == MOVING);
  assign x11    = {1'b0, BallX};
  assign y11    = {1'b0, BallY};

  function automatic logic blocked(input logic [1:0] d, input logic [10:0] x, input logic [10:0] y);
    case (d)
      D_RIGHT: blocked = (x == X_HI);
      D_LEFT:  blocked = (x == X_LO);
      D_DOWN:  blocked = (y == Y_HI);
      default: blocked = (y == Y_LO);
    endcase
  endfunction

  always_comb begin
    key_vld = 1'b1;
    key_dir = D_RIGHT;
    case (keycode)
      8'h07:   key_dir = D_RIGHT;
      8'h04:   key_dir = D_LEFT;
      8'h16:   key_dir = D_DOWN;
      8'h1A:   key_dir = D_UP;
      default: key_vld = 1'b0;
    endcase
  end

  always_comb begin
    live     = key_vld | (pend_cnt != 8'd0);
    req_dir  = key_vld ? key_dir : pend_dir;
    turn_ok  = live & ~blocked(req_dir, x11, y11);
    cont_ok  = (state == MOVING) & ~blocked(dir, x11, y11);
    move_vld = turn_ok | cont_ok;
    move_dir = turn_ok ? req_dir : dir;
    dir_nxt  = turn_ok ? req_dir : dir;

    // Distances shorter than STEP snap onto the limit instead of overshooting.
    x_nxt = x11;
    y_nxt = y11;
    if (move_vld) begin
      case (move_dir)
        D_RIGHT: x_nxt = (x11 + STEP11 >= X_HI) ? X_HI : x11 + STEP11;
        D_LEFT:  x_nxt = (x11 <= X_LO + STEP11) ? X_LO : x11 - STEP11;
        D_DOWN:  y_nxt = (y11 + STEP11 >= Y_HI) ? Y_HI : y11 + STEP11;
        default: y_nxt = (y11 <= Y_LO + STEP11) ? Y_LO : y11 - STEP11;
      endcase
    end

    state_nxt = state;
    if (move_vld)
      state_nxt = MOVING;
    else if (state == MOVING)
      state_nxt = STOPPED;

    pend_dir_nxt     = pend_dir;
    pend_cnt_nxt     = pend_cnt;
    turn_pending_nxt = turn_pending;
    if (turn_ok) begin
      pend_cnt_nxt     = 8'd0;
      turn_pending_nxt = 1'b0;
    end else if (key_vld) begin
      pend_dir_nxt     = key_dir;
      pend_cnt_nxt     = HOLD8;
      turn_pending_nxt = 1'b1;
    end else if (pend_cnt != 8'd0) begin
      pend_cnt_nxt     = pend_cnt - 8'd1;
      turn_pending_nxt = (pend_cnt != 8'd1);
    end

    // The mouth animates only on frames where the sprite actually moves.
    anim_cnt_nxt   = anim_cnt;
    anim_frame_nxt = anim_frame;
    if (move_vld) begin
      if (anim_cnt == ANIM_LAST) begin
        anim_cnt_nxt   = 8'd0;
        anim_frame_nxt = anim_frame + 2'd1;
      end else begin
        anim_cnt_nxt = anim_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      BallX        <= 10'(X_CENTER);
      BallY        <= 10'(Y_CENTER);
      dir          <= D_RIGHT;
      state        <= IDLE;
      pend_dir     <= D_RIGHT;
      pend_cnt     <= 8'd0;
      turn_pending <= 1'b0;
      anim_cnt     <= 8'd0;
      anim_frame   <= 2'd0;
    end else if (enable) begin
      BallX        <= x_nxt[9:0];
      BallY        <= y_nxt[9:0];
      dir          <= dir_nxt;
      state        <= state_nxt;
      pend_dir     <= pend_dir_nxt;
      pend_cnt     <= pend_cnt_nxt;
      turn_pending <= turn_pending_nxt;
      anim_cnt     <= anim_cnt_nxt;
      anim_frame   <= anim_frame_nxt;
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// Scoreboarded random/directed bench: two DUTs (STEP=1 and STEP=2) share stimulus and are checked
// against a per-frame behavioural model of the sprite rules.
module tb_pacman_mover;

  localparam int XC = 202, YC = 253, SZ = 13, HOLD = 8, ANIM = 4;
  localparam int XLO = 0 + SZ, XHI = 404 - SZ, YLO = 0 + SZ, YHI = 447 - SZ;
  localparam int ST_IDLE = 0, ST_MOV = 1, ST_STOP = 2;

  typedef struct {
    int x, y, dir, st, pcnt, pdir, acnt, afr;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] keycode = 8'h00;

  logic [9:0] x0, y0, s0, x1, y1, s1;
  logic [1:0] d0, d1, af0, af1;
  logic       mv0, mv1, tp0, tp1;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  mdl_t m0, m1;

  pacman_mover u0 (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .keycode(keycode),
    .BallX(x0), .BallY(y0), .BallS(s0), .dir(d0), .moving(mv0),
    .turn_pending(tp0), .anim_frame(af0)
  );

  pacman_mover #(.STEP(2)) u1 (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .keycode(keycode),
    .BallX(x1), .BallY(y1), .BallS(s1), .dir(d1), .moving(mv1),
    .turn_pending(tp1), .anim_frame(af1)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.x = XC; m.y = YC; m.dir = 0; m.st = ST_IDLE;
    m.pcnt = 0; m.pdir = 0; m.acnt = 0; m.afr = 0;
    return m;
  endfunction

  function automatic bit at_wall(mdl_t m, int d);
    return (d == 0 && m.x == XHI) || (d == 1 && m.x == XLO) ||
           (d == 2 && m.y == YHI) || (d == 3 && m.y == YLO);
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int stp, bit en, logic [7:0] key);
    int kd, md, want;
    bit moved;
    if (!en) return m;
    case (key)
      8'h07: kd = 0;
      8'h04: kd = 1;
      8'h16: kd = 2;
      8'h1A: kd = 3;
      default: kd = -1;
    endcase
    moved = 0;
    md = m.dir;
    want = (kd >= 0) ? kd : m.pdir;
    if ((kd >= 0 || m.pcnt > 0) && !at_wall(m, want)) begin
      md = want; m.dir = want; m.pcnt = 0; moved = 1;
    end else begin
      if (m.st == ST_MOV && !at_wall(m, m.dir)) moved = 1;
      if (kd >= 0) begin
        m.pdir = kd; m.pcnt = HOLD;
      end else if (m.pcnt > 0) begin
        m.pcnt = m.pcnt - 1;
      end
    end
    if (moved) begin
      case (md)
        0: m.x = (m.x + stp > XHI) ? XHI : m.x + stp;
        1: m.x = (m.x - stp < XLO) ? XLO : m.x - stp;
        2: m.y = (m.y + stp > YHI) ? YHI : m.y + stp;
        default: m.y = (m.y - stp < YLO) ? YLO : m.y - stp;
      endcase
      m.st = ST_MOV;
      m.acnt = m.acnt + 1;
      if (m.acnt == ANIM) begin
        m.acnt = 0;
        m.afr = (m.afr + 1) % 4;
      end
    end else if (m.st == ST_MOV) begin
      m.st = ST_STOP;
    end
    return m;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string tag, mdl_t m, logic [9:0] bx, logic [9:0] by, logic [9:0] bs,
                         logic [1:0] d, logic mv, logic tp, logic [1:0] af);
    chk({tag, ".BallX"}, int'(bx), m.x);
    chk({tag, ".BallY"}, int'(by), m.y);
    chk({tag, ".BallS"}, int'(bs), SZ);
    chk({tag, ".dir"}, int'(d), m.dir);
    chk({tag, ".moving"}, int'(mv), (m.st == ST_MOV) ? 1 : 0);
    chk({tag, ".turn_pending"}, int'(tp), (m.pcnt > 0) ? 1 : 0);
    chk({tag, ".anim_frame"}, int'(af), m.afr);
  endtask

  // Monitor: one expected entry is consumed per modelled frame edge.
  always @(posedge frame_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_dut("step1", e.a, x0, y0, s0, d0, mv0, tp0, af0);
      cmp_dut("step2", e.b, x1, y1, s1, d1, mv1, tp1, af1);
    end
  end

  task automatic frame(input bit en, input logic [7:0] key);
    exp_t e;
    @(negedge frame_clk);
    enable = en;
    keycode = key;
    m0 = mdl_step(m0, 1, en, key);
    m1 = mdl_step(m1, 2, en, key);
    e.a = m0;
    e.b = m1;
    exp_q.push_back(e);
  endtask

  task automatic frames(input int n, input logic [7:0] key);
    for (int i = 0; i < n; i++) frame(1'b1, key);
  endtask

  // Asynchronous reset asserted in the middle of the low phase, checked before any edge.
  task automatic do_reset();
    @(negedge frame_clk);
    enable = 1'b0;
    keycode = 8'h00;
    #2;
    Reset = 1'b1;
    #1;
    m0 = mdl_reset();
    m1 = mdl_reset();
    cmp_dut("rst1", m0, x0, y0, s0, d0, mv0, tp0, af0);
    cmp_dut("rst2", m1, x1, y1, s1, d1, mv1, tp1, af1);
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  initial begin
    logic [7:0] keys [5];
    keys[0] = 8'h07; keys[1] = 8'h04; keys[2] = 8'h16; keys[3] = 8'h1A; keys[4] = 8'h00;
    m0 = mdl_reset();
    m1 = mdl_reset();

    do_reset();
    // First move right, then coast.
    frame(1'b1, 8'h07);
    frames(10, 8'h00);
    // Immediate turn up while moving right, then coast to the top wall.
    frame(1'b1, 8'h1A);
    frames(260, 8'h00);
    // Blocked request at the top: buffered, then expires.
    frame(1'b1, 8'h1A);
    frames(12, 8'h00);
    // Run right into the wall and sit stopped.
    frame(1'b1, 8'h07);
    frames(220, 8'h00);
    frame(1'b1, 8'h07);
    frames(12, 8'h00);
    // Reverse, then buffer a blocked up request and freeze mid-motion.
    frame(1'b1, 8'h04);
    frames(6, 8'h00);
    frame(1'b1, 8'h1A);
    frames(2, 8'h00);
    for (int i = 0; i < 5; i++) frame(1'b0, keys[i]);
    frames(4, 8'h00);
    // Reset while moving.
    do_reset();
    frame(1'b1, 8'h16);
    frames(5, 8'h00);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] k;
      bit en;
      en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0: k = keys[0];
        1: k = keys[1];
        2: k = keys[2];
        3: k = keys[3];
        4: k = 8'($urandom);
        default: k = 8'h00;
      endcase
      frame(en, k);
    end

    @(negedge frame_clk);
    @(negedge frame_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
